// File: rtl/bbprx_pulse_packer.sv
// Per-pulse sample framer feeding the RX buffer: skip, capture, zero-pad, 4-word trailer; 256 words per pulse.
// Optional pairwise averaging is compiled in with BBPRX_PACKER_DECIM2_EN.
module bbprx_pulse_packer #(
  parameter int unsigned PKT_WORDS     = 256,
  parameter int unsigned TRAILER_WORDS = 4
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        trig,
  input  logic        sample_strobe,
  input  logic [15:0] sample,
  input  logic [15:0] delay,
  input  logic [7:0]  n_samples,
  input  logic        decim2,
  input  logic        clear_status,
  output logic        rxstrobe,
  output logic [15:0] data,
  output logic        busy,
  output logic        trig_dropped
);

  localparam int unsigned MAX_SAMPLES = PKT_WORDS - TRAILER_WORDS;
  localparam logic [7:0]  MAX_W       = 8'(MAX_SAMPLES);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_SAMPLE, S_PAD, S_TRAILER} state_t;

  state_t      state, state_nxt;
  logic        trig_d;
  logic [15:0] dly_cnt, dly_nxt;
  logic [7:0]  n_lat, n_lat_nxt;
  logic [7:0]  word_cnt, word_nxt;
  logic [1:0]  tr_cnt, tr_nxt;
  logic [31:0] tick_cnt, tick_nxt;
  logic [31:0] tick_lat, tick_lat_nxt;
  logic [31:0] pulse_cnt, pulse_nxt;
  logic        strobe_nxt;
  logic [15:0] data_nxt;
  logic        dropped_nxt;
  logic        trig_edge, accept, emit;
  logic [15:0] emit_word;
  logic [7:0]  n_clamp;

`ifdef BBPRX_PACKER_DECIM2_EN
  logic        dec_lat, dec_nxt;
  logic        half, half_nxt;
  logic [15:0] pair_a, pair_nxt;
  logic [16:0] pair_sum;
`else
  logic        unused_decim2;
  assign unused_decim2 = decim2;
`endif

  assign trig_edge = trig & ~trig_d;
  assign accept    = trig_edge & enable & (state == S_IDLE);
  assign n_clamp   = (n_samples > MAX_W) ? MAX_W : n_samples;

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    dly_nxt      = dly_cnt;
    n_lat_nxt    = n_lat;
    word_nxt     = word_cnt;
    tr_nxt       = tr_cnt;
    tick_nxt     = (tick_cnt == 32'hFFFF_FFFF) ? tick_cnt : tick_cnt + 32'd1;
    tick_lat_nxt = tick_lat;
    pulse_nxt    = pulse_cnt;
    strobe_nxt   = 1'b0;
    data_nxt     = data;
    dropped_nxt  = trig_dropped;
    emit         = 1'b0;
    emit_word    = sample;
`ifdef BBPRX_PACKER_DECIM2_EN
    dec_nxt      = dec_lat;
    half_nxt     = half;
    pair_nxt     = pair_a;
    pair_sum     = 17'(pair_a) + 17'(sample);
`endif

    // A new drop indication takes priority over a clear in the same cycle
    if (trig_edge && !accept) dropped_nxt = 1'b1;
    else if (clear_status)    dropped_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          dly_nxt      = delay;
          n_lat_nxt    = n_clamp;
          tick_lat_nxt = tick_cnt;
          pulse_nxt    = pulse_cnt + 32'd1;
          tick_nxt     = 32'd0;
          word_nxt     = 8'd0;
          tr_nxt       = 2'd0;
`ifdef BBPRX_PACKER_DECIM2_EN
          dec_nxt      = decim2;
          half_nxt     = 1'b0;
`endif
          if (delay != 16'd0)      state_nxt = S_DELAY;
          else if (n_clamp == 8'd0) state_nxt = S_PAD;
          else                     state_nxt = S_SAMPLE;
        end
      end
      S_DELAY: begin
        if (sample_strobe) begin
          dly_nxt = dly_cnt - 16'd1;
          if (dly_cnt == 16'd1) state_nxt = (n_lat == 8'd0) ? S_PAD : S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (sample_strobe) begin
`ifdef BBPRX_PACKER_DECIM2_EN
          if (dec_lat && !half) begin
            half_nxt = 1'b1;
            pair_nxt = sample;
          end else begin
            half_nxt  = 1'b0;
            emit      = 1'b1;
            emit_word = dec_lat ? pair_sum[16:1] : sample;
          end
`else
          emit = 1'b1;
`endif
        end
        if (emit) begin
          strobe_nxt = 1'b1;
          data_nxt   = emit_word;
          word_nxt   = word_cnt + 8'd1;
          if (word_cnt + 8'd1 == n_lat) state_nxt = (n_lat == MAX_W) ? S_TRAILER : S_PAD;
        end
      end
      S_PAD: begin
        strobe_nxt = 1'b1;
        data_nxt   = 16'h0000;
        word_nxt   = word_cnt + 8'd1;
        if (word_cnt == MAX_W - 8'd1) state_nxt = S_TRAILER;
      end
      S_TRAILER: begin
        strobe_nxt = 1'b1;
        case (tr_cnt)
          2'd0:    data_nxt = pulse_cnt[15:0];
          2'd1:    data_nxt = pulse_cnt[31:16];
          2'd2:    data_nxt = tick_lat[15:0];
          default: data_nxt = tick_lat[31:16];
        endcase
        tr_nxt = tr_cnt + 2'd1;
        if (tr_cnt == 2'd3) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge rxclk) begin
    if (reset) begin
      state        <= S_IDLE;
      trig_d       <= 1'b0;
      dly_cnt      <= 16'd0;
      n_lat        <= 8'd0;
      word_cnt     <= 8'd0;
      tr_cnt       <= 2'd0;
      tick_cnt     <= 32'd0;
      tick_lat     <= 32'd0;
      pulse_cnt    <= 32'd0;
      rxstrobe     <= 1'b0;
      data         <= 16'h0000;
      busy         <= 1'b0;
      trig_dropped <= 1'b0;
`ifdef BBPRX_PACKER_DECIM2_EN
      dec_lat      <= 1'b0;
      half         <= 1'b0;
      pair_a       <= 16'h0000;
`endif
    end else begin
      state        <= state_nxt;
      trig_d       <= trig;
      dly_cnt      <= dly_nxt;
      n_lat        <= n_lat_nxt;
      word_cnt     <= word_nxt;
      tr_cnt       <= tr_nxt;
      tick_cnt     <= tick_nxt;
      tick_lat     <= tick_lat_nxt;
      pulse_cnt    <= pulse_nxt;
      rxstrobe     <= strobe_nxt;
      data         <= data_nxt;
      busy         <= (state_nxt != S_IDLE);
      trig_dropped <= dropped_nxt;
`ifdef BBPRX_PACKER_DECIM2_EN
      dec_lat      <= dec_nxt;
      half         <= half_nxt;
      pair_a       <= pair_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bbprx_pulse_packer.sv
// Directed bench for bbprx_pulse_packer: collects every strobed word per pulse and checks
// payload, padding, trailer, drop flag and reset abandonment against hand-derived values.
module tb_bbprx_pulse_packer;

  logic        rxclk = 1'b0;
  logic        reset, enable, trig, sample_strobe, decim2, clear_status;
  logic [15:0] sample, delay;
  logic [7:0]  n_samples;
  logic        rxstrobe, busy, trig_dropped;
  logic [15:0] data;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          nw = 0;
  logic [15:0] words [0:299];
  logic [15:0] exp_w [0:255];
  int unsigned rst_cyc, fire_cyc, ref_cyc;
  int unsigned exp_tick;
  int          exp_pulse;

  bbprx_pulse_packer dut (
    .rxclk(rxclk), .reset(reset), .enable(enable), .trig(trig),
    .sample_strobe(sample_strobe), .sample(sample), .delay(delay),
    .n_samples(n_samples), .decim2(decim2), .clear_status(clear_status),
    .rxstrobe(rxstrobe), .data(data), .busy(busy), .trig_dropped(trig_dropped)
  );

  always #5 rxclk = ~rxclk;
  always @(posedge rxclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and capture any strobed word
  task automatic tick_cycle();
    @(negedge rxclk);
    if (rxstrobe === 1'b1) begin
      if (nw < 300) words[nw] = data;
      nw++;
    end
  endtask

  task automatic fire(input logic [15:0] dly, input logic [7:0] ns, input logic dec);
    nw = 0;
    delay = dly; n_samples = ns; decim2 = dec;
    trig = 1'b1; sample_strobe = 1'b0;
    tick_cycle();
    fire_cyc = cyc;
    trig = 1'b0;
  endtask

  task automatic stream(input int max_cyc, input logic stb, input logic [15:0] s0,
                        input logic [15:0] inc, input int retrig, input int stop_nw);
    sample_strobe = stb; sample = s0;
    for (int i = 0; i < max_cyc && nw < stop_nw; i++) begin
      tick_cycle();
      sample = sample + inc;
      if (i == retrig) begin trig = 1'b1; clear_status = 1'b1; end
      else if (i == retrig + 1) begin trig = 1'b0; clear_status = 1'b0; end
    end
    sample_strobe = 1'b0; trig = 1'b0; clear_status = 1'b0;
    repeat (4) tick_cycle();
  endtask

  task automatic build_exp(input int n, input int first, input int inc,
                           input int pulse, input int unsigned tk);
    for (int i = 0; i < 252; i++) exp_w[i] = (i < n) ? 16'(first + i * inc) : 16'h0000;
    exp_w[252] = 16'(pulse);
    exp_w[253] = 16'(pulse >> 16);
    exp_w[254] = tk[15:0];
    exp_w[255] = tk[31:16];
  endtask

  task automatic check_packet(input string tag);
    int m;
    m = 0;
    chk({tag, " strobes"}, 32'(nw), 32'd256);
    for (int i = 0; i < 256; i++) if (words[i] !== exp_w[i]) m++;
    chk({tag, " word_errs"}, 32'(m), 32'd0);
    chk({tag, " pulse_lo"}, 32'(words[252]), 32'(exp_w[252]));
    chk({tag, " tick_lo"}, 32'(words[254]), 32'(exp_w[254]));
    chk({tag, " tick_hi"}, 32'(words[255]), 32'(exp_w[255]));
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; trig = 1'b0; sample_strobe = 1'b0; decim2 = 1'b0;
    clear_status = 1'b0; sample = 16'h0; delay = 16'h0; n_samples = 8'h0;
    repeat (3) @(negedge rxclk);
    rst_cyc = cyc; reset = 1'b0;
    ref_cyc = rst_cyc; exp_pulse = 0;
    chk("rst rxstrobe", 32'(rxstrobe), 32'd0);
    chk("rst data", 32'(data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst dropped", 32'(trig_dropped), 32'd0);

    // Trigger while disabled is dropped
    fire(16'd0, 8'd5, 1'b0);
    repeat (5) tick_cycle();
    chk("dis strobes", 32'(nw), 32'd0);
    chk("dis busy", 32'(busy), 32'd0);
    chk("dis dropped", 32'(trig_dropped), 32'd1);
    clear_status = 1'b1; tick_cycle(); clear_status = 1'b0;
    chk("dis cleared", 32'(trig_dropped), 32'd0);
    enable = 1'b1;

    // delay 3, 5 samples: words 4..8, pads, trailer
    fire(16'd3, 8'd5, 1'b0);
    chk("p1 busy", 32'(busy), 32'd1);
    exp_pulse = 1; exp_tick = fire_cyc - ref_cyc - 1; ref_cyc = fire_cyc;
    stream(600, 1'b1, 16'd1, 16'd1, -1, 256);
    build_exp(5, 4, 1, exp_pulse, exp_tick);
    chk("p1 w0", 32'(words[0]), 32'd4);
    chk("p1 w4", 32'(words[4]), 32'd8);
    check_packet("p1");

    // n_samples 255 clamps to 252, trailer right after
    fire(16'd0, 8'd255, 1'b0);
    exp_pulse = 2; exp_tick = fire_cyc - ref_cyc - 1; ref_cyc = fire_cyc;
    stream(600, 1'b1, 16'd100, 16'd1, -1, 256);
    build_exp(252, 100, 1, exp_pulse, exp_tick);
    chk("p2 w251", 32'(words[251]), 32'd351);
    check_packet("p2");

    // Retrigger while busy with a coincident clear: drop flag must be set
    fire(16'd5, 8'd3, 1'b0);
    exp_pulse = 3; exp_tick = fire_cyc - ref_cyc - 1; ref_cyc = fire_cyc;
    stream(600, 1'b1, 16'd50, 16'd1, 10, 256);
    build_exp(3, 55, 1, exp_pulse, exp_tick);
    check_packet("p3");
    chk("p3 dropped", 32'(trig_dropped), 32'd1);
    clear_status = 1'b1; tick_cycle(); clear_status = 1'b0;
    chk("p3 cleared", 32'(trig_dropped), 32'd0);

    fire(16'd2, 8'd4, 1'b0);
    exp_pulse = 4; exp_tick = fire_cyc - ref_cyc - 1; ref_cyc = fire_cyc;
    stream(600, 1'b1, 16'd7, 16'd1, -1, 256);
    build_exp(4, 9, 1, exp_pulse, exp_tick);
    check_packet("p4");

    // Reset at word 100 abandons the packet
    fire(16'd0, 8'd200, 1'b0);
    sample_strobe = 1'b1; sample = 16'd1000;
    for (int i = 0; i < 300 && nw < 100; i++) begin
      tick_cycle();
      sample = sample + 16'd1;
    end
    chk("rp w99", 32'(words[99]), 32'd1099);
    reset = 1'b1; sample_strobe = 1'b0;
    tick_cycle();
    rst_cyc = cyc; reset = 1'b0;
    chk("rp rxstrobe", 32'(rxstrobe), 32'd0);
    chk("rp busy", 32'(busy), 32'd0);
    repeat (5) tick_cycle();
    chk("rp no_more", 32'(nw), 32'd100);
    ref_cyc = rst_cyc;

    fire(16'd1, 8'd6, 1'b0);
    exp_pulse = 1; exp_tick = fire_cyc - ref_cyc - 1; ref_cyc = fire_cyc;
    stream(600, 1'b1, 16'd20, 16'd1, -1, 256);
    build_exp(6, 21, 1, exp_pulse, exp_tick);
    check_packet("p5");

    // decim2 request: averaged pairs when compiled in, plain samples otherwise
    fire(16'd0, 8'd2, 1'b1);
    exp_pulse = 2; exp_tick = fire_cyc - ref_cyc - 1; ref_cyc = fire_cyc;
    stream(600, 1'b1, 16'd10, 16'd10, -1, 256);
`ifdef BBPRX_PACKER_DECIM2_EN
    build_exp(2, 15, 20, exp_pulse, exp_tick);
`else
    build_exp(2, 10, 10, exp_pulse, exp_tick);
`endif
    check_packet("dec");

    // n_samples 0, delay 0, no strobes, enable dropped mid-packet: 252 zeros + trailer
    fire(16'd0, 8'd0, 1'b0);
    enable = 1'b0;
    exp_pulse = 3; exp_tick = fire_cyc - ref_cyc - 1; ref_cyc = fire_cyc;
    stream(600, 1'b0, 16'd0, 16'd0, -1, 256);
    build_exp(0, 0, 0, exp_pulse, exp_tick);
    check_packet("pad");
    enable = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
